// File: rtl/frame_gen_param_if.sv
// User payload stream (valid/ready) plus the 8b/10b TX word bus toward the transceiver.
interface frame_gen_param_if #(parameter int BYTES = 2);
   localparam int W = 8 * BYTES;

   logic [W-1:0]     s_data;
   logic             s_valid;
   logic             s_ready;
   logic [W-1:0]     tx_data;
   logic [BYTES-1:0] tx_is_k;

   modport master (output s_data, s_valid, input s_ready, tx_data, tx_is_k);
   modport slave  (input s_data, s_valid, output s_ready, tx_data, tx_is_k);
endinterface

// File: rtl/frame_gen_param.sv
// 8b/10b TX frame generator: comma idles, then SOF+seq, payload, XOR checksum, EOF.
// Every output is registered; the word chosen by the FSM appears one clock later.
module frame_gen_param #(
   parameter int         BYTES         = 2,
   parameter int         PAYLOAD_WORDS = 6,
   parameter int         IDLE_MIN      = 2,
   parameter logic [7:0] COMMA         = 8'hBC,
   parameter logic [7:0] SOF_K         = 8'hFB,
   parameter logic [7:0] EOF_K         = 8'hFD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ready,
   input  logic [1:0]       mode,
   frame_gen_param_if.slave bus,
   output logic [15:0]      frame_cnt,
   output logic             busy
);
   localparam int W  = 8 * BYTES;
   localparam int SW = 8 * (BYTES - 1);
   localparam int IW = $clog2(IDLE_MIN + 1);
   localparam int PW = $clog2(PAYLOAD_WORDS + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_PAY, ST_CSUM, ST_EOF} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idle_cnt_q, idle_cnt_d, idle_inc;
   logic [PW-1:0]    pay_cnt_q, pay_cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [W-1:0]     csum_q, csum_d;
   logic [W-1:0]     ctr_q, ctr_d;
   logic [14:0]      prbs_q, prbs_d, prbs_nxt;
   logic [W-1:0]     prbs_word;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [W-1:0]     tx_data_q, tx_data_d;
   logic [BYTES-1:0] tx_is_k_q, tx_is_k_d;
   logic             s_ready_q, s_ready_d;
   logic             busy_q, busy_d;
   logic [W-1:0]     pay_word;
   logic             pay_take;
   logic [SW-1:0]    seq;

   // PRBS-15 (x^15+x^14+1): W feedback bits per word, first generated bit lands in bit 0.
   always_comb begin
      prbs_word = '0;
      prbs_nxt  = prbs_q;
      for (int i = 0; i < W; i++) begin
         prbs_word[i] = prbs_nxt[14] ^ prbs_nxt[13];
         prbs_nxt     = {prbs_nxt[13:0], prbs_word[i]};
      end
   end

   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = idle_cnt_q;
      pay_cnt_d   = pay_cnt_q;
      mode_d      = mode_q;
      csum_d      = csum_q;
      ctr_d       = ctr_q;
      prbs_d      = prbs_q;
      frame_cnt_d = frame_cnt_q;
      tx_data_d   = '0;
      tx_is_k_d   = '0;
      s_ready_d   = 1'b0;
      busy_d      = 1'b0;
      pay_word    = '0;
      pay_take    = 1'b0;
      seq         = SW'(frame_cnt_q);
      idle_inc    = (idle_cnt_q >= IW'(IDLE_MIN)) ? idle_cnt_q : idle_cnt_q + IW'(1);

      if (ready) begin
         busy_d = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               tx_data_d  = {BYTES{COMMA}};
               tx_is_k_d  = '1;
               idle_cnt_d = idle_inc;
               // The idle word emitted in this cycle counts toward the minimum gap.
               if (idle_inc >= IW'(IDLE_MIN) && mode != 2'd0 &&
                   (mode != 2'd3 || bus.s_valid)) begin
                  state_d = ST_SOF;
                  mode_d  = mode;
               end
            end
            ST_SOF: begin
               tx_data_d = {seq, SOF_K};
               tx_is_k_d = BYTES'(1);
               csum_d    = '0;
               pay_cnt_d = '0;
               s_ready_d = (mode_q == 2'd3);
               state_d   = ST_PAY;
            end
            ST_PAY: begin
               case (mode_q)
                  2'd1: begin
                     pay_word = ctr_q;
                     pay_take = 1'b1;
                     ctr_d    = ctr_q + W'(1);
                  end
                  2'd2: begin
                     pay_word = prbs_word;
                     pay_take = 1'b1;
                     prbs_d   = prbs_nxt;
                  end
                  default: begin
                     pay_word = bus.s_data;
                     pay_take = bus.s_valid;
                  end
               endcase
               if (pay_take) begin
                  tx_data_d = pay_word;
                  csum_d    = csum_q ^ pay_word;
                  pay_cnt_d = pay_cnt_q + PW'(1);
               end else begin
                  tx_data_d = {BYTES{COMMA}};
                  tx_is_k_d = '1;
               end
               if (pay_take && pay_cnt_q == PW'(PAYLOAD_WORDS - 1)) begin
                  state_d = ST_CSUM;
               end else begin
                  s_ready_d = (mode_q == 2'd3);
               end
            end
            ST_CSUM: begin
               tx_data_d = csum_q;
               state_d   = ST_EOF;
            end
            ST_EOF: begin
               tx_data_d   = {{(W-8){1'b0}}, EOF_K};
               tx_is_k_d   = BYTES'(1);
               frame_cnt_d = frame_cnt_q + 16'd1;
               idle_cnt_d  = '0;
               state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         // Link held quiet: abort any frame, keep counter/PRBS/frame_cnt.
         state_d    = ST_IDLE;
         idle_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idle_cnt_q  <= '0;
         pay_cnt_q   <= '0;
         mode_q      <= 2'd0;
         csum_q      <= '0;
         ctr_q       <= '0;
         prbs_q      <= '1;
         frame_cnt_q <= '0;
         tx_data_q   <= '0;
         tx_is_k_q   <= '0;
         s_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         pay_cnt_q   <= pay_cnt_d;
         mode_q      <= mode_d;
         csum_q      <= csum_d;
         ctr_q       <= ctr_d;
         prbs_q      <= prbs_d;
         frame_cnt_q <= frame_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_is_k_q   <= tx_is_k_d;
         s_ready_q   <= s_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.tx_data = tx_data_q;
   assign bus.tx_is_k = tx_is_k_q;
   assign bus.s_ready = s_ready_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = busy_q;
endmodule
